// File: rtl/u_dat_arb.sv
// Two-master arbiter for the single-port data SRAM; port 0 has fixed priority, with a starvation override for port 1.
// Latency: grant and SRAM mux are combinational (0 cycles); read data returns 1 cycle after the granted read.
// Backpressure: a denied master holds its request until its gnt is high; nothing is queued for it.
//
// Ports:
//   clk, rstn                      clock, asynchronous active-low reset
//   m0_a/we/wd/re -> m0_gnt        port 0 (LSU) request, combinational grant
//   m0_vld, m0_rd                  port 0 read return (vld registered)
//   m1_*                           same set for port 1 (DMA / debug loader)
//   dat_a/we/wd/re, dat_rd         SRAM side; dat_rd valid 1 cycle after dat_re
module u_dat_arb #(
    parameter int AW         = 16,
    parameter int STARVE_MAX = 4,
    localparam int CW        = $clog2(STARVE_MAX + 1)
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic [AW-1:0] m0_a,
    input  logic [3:0]    m0_we,
    input  logic [31:0]   m0_wd,
    input  logic [3:0]    m0_re,
    output logic          m0_gnt,
    output logic          m0_vld,
    output logic [31:0]   m0_rd,
    input  logic [AW-1:0] m1_a,
    input  logic [3:0]    m1_we,
    input  logic [31:0]   m1_wd,
    input  logic [3:0]    m1_re,
    output logic          m1_gnt,
    output logic          m1_vld,
    output logic [31:0]   m1_rd,
    output logic [AW-1:0] dat_a,
    output logic [3:0]    dat_we,
    output logic [31:0]   dat_wd,
    output logic [3:0]    dat_re,
    input  logic [31:0]   dat_rd
);

    localparam logic [CW-1:0] SMAX = CW'(STARVE_MAX);

    // Owner of the read currently in flight inside the SRAM.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } own_t;

    own_t          own_q;
    own_t          own_d;
    logic [CW-1:0] starve_cnt;
    logic          frc;
    logic          req0;
    logic          req1;
    logic          gnt0;
    logic          gnt1;

    assign req0 = (|m0_we) | (|m0_re);
    assign req1 = (|m1_we) | (|m1_re);

    // Port 1 takes priority only once it has waited STARVE_MAX cycles.
    assign frc = (starve_cnt == SMAX);

    // Grants are gated by rstn so no SRAM access is issued while in reset.
    assign gnt1 = rstn & req1 & (frc | ~req0);
    assign gnt0 = rstn & req0 & ~gnt1;

    assign m0_gnt = gnt0;
    assign m1_gnt = gnt1;

    // SRAM mux: all-zero when idle so the macro sees no spurious access.
    always_comb begin
        dat_a  = '0;
        dat_we = '0;
        dat_wd = '0;
        dat_re = '0;
        if (gnt0) begin
            dat_a  = m0_a;
            dat_we = m0_we;
            dat_wd = m0_wd;
            dat_re = m0_re;
        end else if (gnt1) begin
            dat_a  = m1_a;
            dat_we = m1_we;
            dat_wd = m1_wd;
            dat_re = m1_re;
        end
    end

    // Starvation counter: counts consecutive denied cycles of a pending
    // port 1 request; a withdrawn request forgets its history.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            starve_cnt <= '0;
        end else if (!req1 || gnt1) begin
            starve_cnt <= '0;
        end else if (starve_cnt != SMAX) begin
            starve_cnt <= starve_cnt + 1'b1;
        end
    end

    // Read-owner FSM: state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            own_q <= OWN_NONE;
        end else begin
            own_q <= own_d;
        end
    end

    // Read-owner FSM: next state. Rewritten every cycle so alternating
    // back-to-back reads each return to the right master.
    always_comb begin
        own_d = OWN_NONE;
        if (gnt0 && (|m0_re)) begin
            own_d = OWN_M0;
        end else if (gnt1 && (|m1_re)) begin
            own_d = OWN_M1;
        end
    end

    // Read-owner FSM: outputs. Read data is steered only to the owner.
    always_comb begin
        m0_vld = 1'b0;
        m1_vld = 1'b0;
        m0_rd  = '0;
        m1_rd  = '0;
        case (own_q)
            OWN_M0: begin
                m0_vld = 1'b1;
                m0_rd  = dat_rd;
            end
            OWN_M1: begin
                m1_vld = 1'b1;
                m1_rd  = dat_rd;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_u_dat_arb.sv
// Directed testbench for u_dat_arb (AW=16, STARVE_MAX=4).
// Inputs change 1 time unit after the rising edge; outputs sampled 1-3 units later.
// Expected values are hand-computed from the arbitration rules.
module tb_u_dat_arb;

    logic        clk;
    logic        rstn;
    logic [15:0] m0_a, m1_a, dat_a;
    logic [3:0]  m0_we, m0_re, m1_we, m1_re, dat_we, dat_re;
    logic [31:0] m0_wd, m1_wd, dat_wd, dat_rd, m0_rd, m1_rd;
    logic        m0_gnt, m0_vld, m1_gnt, m1_vld;

    int checks;
    int failures;

    u_dat_arb #(.AW(16), .STARVE_MAX(4)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .m0_a   (m0_a),
        .m0_we  (m0_we),
        .m0_wd  (m0_wd),
        .m0_re  (m0_re),
        .m0_gnt (m0_gnt),
        .m0_vld (m0_vld),
        .m0_rd  (m0_rd),
        .m1_a   (m1_a),
        .m1_we  (m1_we),
        .m1_wd  (m1_wd),
        .m1_re  (m1_re),
        .m1_gnt (m1_gnt),
        .m1_vld (m1_vld),
        .m1_rd  (m1_rd),
        .dat_a  (dat_a),
        .dat_we (dat_we),
        .dat_wd (dat_wd),
        .dat_re (dat_re),
        .dat_rd (dat_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_a = '0; m0_we = '0; m0_wd = '0; m0_re = '0;
        m1_a = '0; m1_we = '0; m1_wd = '0; m1_re = '0;
    endtask

    // Expected port 1 grants while both ports request continuously.
    logic exp_g [0:5];
    logic prev_g;

    initial begin
        checks   = 0;
        failures = 0;
        dat_rd   = '0;
        idle();

        // Reset with both ports requesting.
        rstn  = 1'b0;
        m0_re = 4'hF; m0_a = 16'h0100;
        m1_we = 4'hF; m1_a = 16'h0200; m1_wd = 32'h12345678;
        step();
        step();
        chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
        chk("rst_m1_gnt", 32'(m1_gnt), 32'd0);
        chk("rst_m0_vld", 32'(m0_vld), 32'd0);
        chk("rst_m1_vld", 32'(m1_vld), 32'd0);
        chk("rst_dat_we", 32'(dat_we), 32'd0);
        rstn = 1'b1;
        #1;
        chk("first_m0_gnt", 32'(m0_gnt), 32'd1);

        // Starvation: both request every cycle -> port 1 every 5th cycle.
        for (int i = 0; i < 11; i++) begin
            #1;
            chk($sformatf("starve_m1_gnt[%0d]", i), 32'(m1_gnt), 32'((i % 5) == 4));
            chk($sformatf("starve_m0_gnt[%0d]", i), 32'(m0_gnt), 32'((i % 5) != 4));
            chk($sformatf("starve_dat_we[%0d]", i), 32'(dat_we), ((i % 5) == 4) ? 32'hF : 32'h0);
            step();
        end
        idle();
        step();
        step();

        // Port 0 read alone.
        m0_re = 4'hF; m0_a = 16'h0010;
        #1;
        chk("rd0_gnt", 32'(m0_gnt), 32'd1);
        chk("rd0_dat_a", 32'(dat_a), 32'h0010);
        chk("rd0_dat_re", 32'(dat_re), 32'hF);
        step();
        idle();
        dat_rd = 32'hDEADBEEF;
        #1;
        chk("rd0_vld", 32'(m0_vld), 32'd1);
        chk("rd0_rd", m0_rd, 32'hDEADBEEF);
        chk("rd0_m1_vld", 32'(m1_vld), 32'd0);
        chk("rd0_m1_rd", m1_rd, 32'h0);
        chk("rd0_idle_dat_re", 32'(dat_re), 32'h0);
        step();
        chk("rd0_vld_gone", 32'(m0_vld), 32'd0);

        // Port 1 write alone.
        m1_we = 4'b0011; m1_wd = 32'h0000A5A5; m1_a = 16'h0004;
        #1;
        chk("wr1_gnt", 32'(m1_gnt), 32'd1);
        chk("wr1_dat_we", 32'(dat_we), 32'h3);
        chk("wr1_dat_a", 32'(dat_a), 32'h0004);
        chk("wr1_dat_wd", dat_wd, 32'h0000A5A5);
        step();
        idle();
        #1;
        chk("wr1_m0_vld", 32'(m0_vld), 32'd0);
        chk("wr1_m1_vld", 32'(m1_vld), 32'd0);
        step();

        // Alternating reads: port 1 forced on its 5th pending cycle.
        exp_g[0] = 1'b0; exp_g[1] = 1'b0; exp_g[2] = 1'b0;
        exp_g[3] = 1'b0; exp_g[4] = 1'b1; exp_g[5] = 1'b0;
        m0_re = 4'hF; m0_a = 16'h0020;
        m1_re = 4'hF; m1_a = 16'h0030;
        for (int i = 0; i <= 6; i++) begin
            dat_rd = 32'h1000 + 32'(i);
            #1;
            prev_g = (i > 0) ? exp_g[i-1] : 1'b0;
            chk($sformatf("alt_m0_vld[%0d]", i), 32'(m0_vld), 32'((i > 0) && !prev_g));
            chk($sformatf("alt_m1_vld[%0d]", i), 32'(m1_vld), 32'((i > 0) && prev_g));
            chk($sformatf("alt_m0_rd[%0d]", i), m0_rd, ((i > 0) && !prev_g) ? dat_rd : 32'h0);
            chk($sformatf("alt_m1_rd[%0d]", i), m1_rd, ((i > 0) && prev_g) ? dat_rd : 32'h0);
            chk($sformatf("alt_both_vld[%0d]", i), 32'(m0_vld & m1_vld), 32'd0);
            if (i < 6) begin
                chk($sformatf("alt_m1_gnt[%0d]", i), 32'(m1_gnt), 32'(exp_g[i]));
                step();
            end
        end
        idle();
        step();
        step();

        // Reset mid-read: port 1 read granted, rstn pulsed before the edge.
        m1_re = 4'hF; m1_a = 16'h0040;
        #1;
        chk("rst_rd1_gnt", 32'(m1_gnt), 32'd1);
        rstn = 1'b0;
        #1;
        chk("rst_rd1_gnt_low", 32'(m1_gnt), 32'd0);
        idle();
        rstn = 1'b1;
        step();
        chk("rst_rd1_vld", 32'(m1_vld), 32'd0);
        step();
        chk("rst_rd1_vld2", 32'(m1_vld), 32'd0);

        // Counter restart: build up starvation, reset, then port 1 needs 4 more denials.
        m0_re = 4'hF; m0_a = 16'h0050;
        m1_re = 4'hF; m1_a = 16'h0060;
        step();
        step();
        #1;
        rstn = 1'b0;
        #1;
        chk("rst_cnt_m0_vld", 32'(m0_vld), 32'd0);
        rstn = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rst_cnt_m1_gnt[%0d]", i), 32'(m1_gnt), 32'(i == 4));
            step();
        end
        idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Bounded run: a stalled simulation is reported rather than hanging.
    initial begin
        #20000;
        failures++;
        $display("FAIL timeout: got running expected finished");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
